// File: rtl/alu_sequencer.sv
// Command FIFO feeding an external combinational ALU: each popped command is held
// on the ALU inputs for SETTLE cycles, then the ALU outputs are captured and held until accepted.
module alu_sequencer #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_a,
    input  logic [31:0]               in_b,
    input  logic [2:0]                in_cmd,
    output logic [31:0]               alu_a,
    output logic [31:0]               alu_b,
    output logic [2:0]                alu_cmd,
    input  logic [31:0]               alu_result,
    input  logic                      alu_carryout,
    input  logic                      alu_zero,
    input  logic                      alu_overflow,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_result,
    output logic                      out_carryout,
    output logic                      out_zero,
    output logic                      out_overflow,
    output logic [2:0]                out_cmd,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} state_t;

    state_t          state;
    logic [3:0]      settle_cnt;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [66:0]     mem [DEPTH];
    logic [66:0]     head;
    logic            push;
    logic            pop;

    assign in_ready = (count < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    // A pop happens only when the FSM is ready to launch the next command.
    assign pop      = (count != '0) &&
                      ((state == ST_IDLE) || ((state == ST_HOLD) && out_ready));
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b, in_cmd};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            settle_cnt   <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_cmd      <= '0;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_carryout <= 1'b0;
            out_zero     <= 1'b0;
            out_overflow <= 1'b0;
            out_cmd      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        alu_a      <= head[66:35];
                        alu_b      <= head[34:3];
                        alu_cmd    <= head[2:0];
                        settle_cnt <= 4'(SETTLE);
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt - 1'b1;
                    if (settle_cnt == 4'd1) begin
                        out_result   <= alu_result;
                        out_carryout <= alu_carryout;
                        out_zero     <= alu_zero;
                        out_overflow <= alu_overflow;
                        out_cmd      <= alu_cmd;
                        out_valid    <= 1'b1;
                        state        <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (pop) begin
                            alu_a      <= head[66:35];
                            alu_b      <= head[34:3];
                            alu_cmd    <= head[2:0];
                            settle_cnt <= 4'(SETTLE);
                            state      <= ST_SETTLE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
